seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seqdet_pkg.sv | 75 +++++++
 rtl/seqdet_sat_counter.sv | 33 +++
 rtl/seq_detector_param.sv | 102 ++++++++++
 tb/tb_seq_detector_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared elaboration-time helpers for the serial sequence detector: KMP next-state
// computation over a pattern of up to 16 bits, and the state-width helper.
package seqdet_pkg;

    localparam int MAX_PAT_LEN = 16;

    typedef enum logic [1:0] {
        EV_HOLD  = 2'd0,
        EV_STEP  = 2'd1,
        EV_MATCH = 2'd2
    } seq_event_e;

    function automatic int state_width(input int pat_len);
        return (pat_len <= 2) ? 1 : $clog2(pat_len);
    endfunction

    // Bit idx of the pattern in arrival order (idx 0 is the MSB, received first).
    function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pat, input int len,
                                     input int idx);
        logic [MAX_PAT_LEN-1:0] t;
        t = pat >> (len - 1 - idx);
        return t[0];
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, then x).
    function automatic int prefix_match_len(input logic [MAX_PAT_LEN-1:0] pat, input int len,
                                            input int k, input logic x);
        int   best;
        int   si;
        logic ok;
        logic sb;
        best = 0;
        for (int m = 1; m <= k + 1; m++) begin
            if (m <= len) begin
                ok = 1'b1;
                for (int i = 0; i < m; i++) begin
                    si = k + 1 - m + i;
                    sb = (si == k) ? x : pat_bit(pat, len, si);
                    if (sb != pat_bit(pat, len, i)) ok = 1'b0;
                end
                if (ok) best = m;
            end
        end
        return best;
    endfunction

    // Longest proper border of the full pattern: where an overlapping match resumes.
    function automatic int fail_len(input logic [MAX_PAT_LEN-1:0] pat, input int len);
        int   best;
        logic ok;
        best = 0;
        for (int m = 1; m < len; m++) begin
            ok = 1'b1;
            for (int i = 0; i < m; i++) begin
                if (pat_bit(pat, len, len - m + i) != pat_bit(pat, len, i)) ok = 1'b0;
            end
            if (ok) best = m;
        end
        return best;
    endfunction

    function automatic int next_state(input logic [MAX_PAT_LEN-1:0] pat, input int len,
                                      input int k, input logic x, input bit overlap);
        int m;
        m = prefix_match_len(pat, len, k, x);
        if (m >= len) return overlap ? fail_len(pat, len) : 0;
        return m;
    endfunction

    function automatic bit is_match(input logic [MAX_PAT_LEN-1:0] pat, input int len,
                                    input int k, input logic x);
        return prefix_match_len(pat, len, k, x) >= len;
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating match counter; holds at all-ones and flags saturation.
module seqdet_sat_counter
    import seqdet_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CP,
    input  logic             CLRn,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_w;

    assign sat_w = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !sat_w) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CP or negedge CLRn) begin
        if (!CLRn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign sat = sat_w;

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with elaboration-time KMP transition table.
// Optional saturating match counter enabled by macro SEQDET_COUNT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
//   0   | no prefix of the pattern matched by the recent bits
//   k   | the last k consumed bits equal the first k pattern bits
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                              CP,
    input  logic                              CLRn,
    input  logic                              X,
    input  logic                              EN,
    output logic [state_width(PAT_LEN)-1:0]   state,
    output logic                              Z,
    output logic [CNT_W-1:0]                  match_cnt,
    output logic                              cnt_sat
);

    localparam int SW = state_width(PAT_LEN);
    localparam int NS = 2 ** SW;
    localparam logic [MAX_PAT_LEN-1:0] PAT_EXT = MAX_PAT_LEN'(PATTERN);

    logic [NS-1:0][SW-1:0] nxt0_tbl;
    logic [NS-1:0][SW-1:0] nxt1_tbl;
    logic [NS-1:0]         hit0_tbl;
    logic [NS-1:0]         hit1_tbl;

    // Unreachable encodings (>= PAT_LEN) fall back to 0 so a corrupted state self-recovers.
    for (genvar g = 0; g < NS; g++) begin : g_tbl
        if (g < PAT_LEN) begin : g_live
            localparam int NX0 = next_state(PAT_EXT, PAT_LEN, g, 1'b0, OVERLAP);
            localparam int NX1 = next_state(PAT_EXT, PAT_LEN, g, 1'b1, OVERLAP);
            localparam bit HT0 = is_match(PAT_EXT, PAT_LEN, g, 1'b0);
            localparam bit HT1 = is_match(PAT_EXT, PAT_LEN, g, 1'b1);
            assign nxt0_tbl[g] = SW'(NX0);
            assign nxt1_tbl[g] = SW'(NX1);
            assign hit0_tbl[g] = HT0;
            assign hit1_tbl[g] = HT1;
        end else begin : g_dead
            assign nxt0_tbl[g] = '0;
            assign nxt1_tbl[g] = '0;
            assign hit0_tbl[g] = 1'b0;
            assign hit1_tbl[g] = 1'b0;
        end
    end

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          z_q;
    logic          z_d;
    logic [SW-1:0] nxt;
    logic          hit;
    seq_event_e    ev;

    always_comb begin
        nxt     = state_q;
        hit     = 1'b0;
        ev      = EV_HOLD;
        state_d = state_q;
        if (EN) begin
            nxt     = X ? nxt1_tbl[state_q] : nxt0_tbl[state_q];
            hit     = X ? hit1_tbl[state_q] : hit0_tbl[state_q];
            ev      = hit ? EV_MATCH : EV_STEP;
            state_d = nxt;
        end
        z_d = (ev == EV_MATCH);
    end

    always_ff @(posedge CP or negedge CLRn) begin
        if (!CLRn) begin
            state_q <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    assign state = state_q;
    assign Z     = z_q;

`ifdef SEQDET_COUNT_EN
    seqdet_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .CP   (CP),
        .CLRn (CLRn),
        .inc  (z_d),
        .cnt  (match_cnt),
        .sat  (cnt_sat)
    );
`else
    assign match_cnt = '0;
    assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: four configurations share one stimulus stream and are
// checked against a bit-history model every cycle, plus directed literal expectations.
module tb_seq_detector_param;

`ifdef SEQDET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic CP, CLRn, X, EN;

    logic [1:0] st_ov, st_no, st_sat;
    logic [2:0] st_p5;
    logic       z_ov, z_no, z_sat, z_p5;
    logic [7:0] c_ov, c_no, c_p5;
    logic [1:0] c_sat;
    logic       s_ov, s_no, s_sat, s_p5;

    seq_detector_param u_ov (
        .CP(CP), .CLRn(CLRn), .X(X), .EN(EN),
        .state(st_ov), .Z(z_ov), .match_cnt(c_ov), .cnt_sat(s_ov));

    seq_detector_param #(.OVERLAP(1'b0)) u_no (
        .CP(CP), .CLRn(CLRn), .X(X), .EN(EN),
        .state(st_no), .Z(z_no), .match_cnt(c_no), .cnt_sat(s_no));

    seq_detector_param #(.CNT_W(2)) u_sat (
        .CP(CP), .CLRn(CLRn), .X(X), .EN(EN),
        .state(st_sat), .Z(z_sat), .match_cnt(c_sat), .cnt_sat(s_sat));

    seq_detector_param #(.PAT_LEN(5), .PATTERN(5'b11011)) u_p5 (
        .CP(CP), .CLRn(CLRn), .X(X), .EN(EN),
        .state(st_p5), .Z(z_p5), .match_cnt(c_p5), .cnt_sat(s_p5));

    initial CP = 1'b0;
    always #5 CP = ~CP;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: remembers consumed bits since the last reset or non-overlap restart.
    logic [15:0] m_pat [4];
    int          m_len [4];
    bit          m_ov  [4];
    int          m_cw  [4];
    logic [63:0] hist  [4];
    int          nb    [4];
    int          cnt   [4];
    int          e_state [4];
    bit          e_z   [4];

    function automatic bit sfx(input int i, input int m);
        for (int j = 0; j < m; j++)
            if (hist[i][m-1-j] != m_pat[i][m_len[i]-1-j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int e_cnt(input int i);
        return CNT_ON ? cnt[i] : 0;
    endfunction

    function automatic int e_sat(input int i);
        return (CNT_ON && cnt[i] == (2 ** m_cw[i]) - 1) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            hist[i] = '0; nb[i] = 0; cnt[i] = 0; e_state[i] = 0; e_z[i] = 1'b0;
        end
    endtask

    task automatic model_update(input logic x, input logic en);
        for (int i = 0; i < 4; i++) begin
            e_z[i] = 1'b0;
            if (en) begin
                hist[i] = {hist[i][62:0], x};
                nb[i]   = (nb[i] < 40) ? nb[i] + 1 : 40;
                if (nb[i] >= m_len[i] && sfx(i, m_len[i])) begin
                    e_z[i] = 1'b1;
                    if (cnt[i] < (2 ** m_cw[i]) - 1) cnt[i]++;
                    if (!m_ov[i]) nb[i] = 0;
                end
                e_state[i] = 0;
                for (int m = m_len[i] - 1; m >= 1; m--)
                    if (e_state[i] == 0 && m <= nb[i] && sfx(i, m)) e_state[i] = m;
            end
        end
    endtask

    always @(negedge CP) begin
        chk("ov_state", int'(st_ov), e_state[0]);  chk("ov_z", int'(z_ov), int'(e_z[0]));
        chk("ov_cnt", int'(c_ov), e_cnt(0));       chk("ov_sat", int'(s_ov), e_sat(0));
        chk("no_state", int'(st_no), e_state[1]);  chk("no_z", int'(z_no), int'(e_z[1]));
        chk("no_cnt", int'(c_no), e_cnt(1));       chk("no_sat", int'(s_no), e_sat(1));
        chk("sat_state", int'(st_sat), e_state[2]); chk("sat_z", int'(z_sat), int'(e_z[2]));
        chk("sat_cnt", int'(c_sat), e_cnt(2));     chk("sat_sat", int'(s_sat), e_sat(2));
        chk("p5_state", int'(st_p5), e_state[3]);  chk("p5_z", int'(z_p5), int'(e_z[3]));
        chk("p5_cnt", int'(c_p5), e_cnt(3));       chk("p5_sat", int'(s_p5), e_sat(3));
    end

    task automatic step(input logic x, input logic en);
        @(negedge CP);
        X  = x;
        EN = en;
        @(posedge CP);
        model_update(x, en);
        #1;
    endtask

    task automatic reset_pulse();
        CLRn = 1'b0;
        model_reset();
        #1;
        chk("rst_ov_state", int'(st_ov), 0);
        chk("rst_ov_z", int'(z_ov), 0);
        chk("rst_ov_cnt", int'(c_ov), 0);
        chk("rst_sat_flag", int'(s_sat), 0);
        #1;
        CLRn = 1'b1;
    endtask

    logic [6:0]  s027;
    logic [4:0]  s029;
    logic [31:0] long_x, long_en;

    initial begin
        m_pat[0] = 16'b1101;  m_len[0] = 4; m_ov[0] = 1'b1; m_cw[0] = 8;
        m_pat[1] = 16'b1101;  m_len[1] = 4; m_ov[1] = 1'b0; m_cw[1] = 8;
        m_pat[2] = 16'b1101;  m_len[2] = 4; m_ov[2] = 1'b1; m_cw[2] = 2;
        m_pat[3] = 16'b11011; m_len[3] = 5; m_ov[3] = 1'b1; m_cw[3] = 8;
        model_reset();
        CLRn = 1'b0; X = 1'b0; EN = 1'b0;
        @(negedge CP);
        @(negedge CP);
        #1 CLRn = 1'b1;

        // Overlap vs non-overlap on 1101101.
        s027 = 7'b1101101;
        for (int i = 6; i >= 0; i--) begin
            step(s027[i], 1'b1);
            if (i == 3) begin
                chk("ov_b4_z", int'(z_ov), 1);   chk("ov_b4_state", int'(st_ov), 1);
                chk("no_b4_z", int'(z_no), 1);   chk("no_b4_state", int'(st_no), 0);
            end
        end
        chk("ov_b7_z", int'(z_ov), 1);
        chk("ov_b7_cnt", int'(c_ov), CNT_ON ? 2 : 0);
        chk("no_b7_z", int'(z_no), 0);
        chk("no_b7_cnt", int'(c_no), CNT_ON ? 1 : 0);

        // Drive u_ov to state 3, then reset between edges.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("ov_pre_rst_state", int'(st_ov), 3);
        reset_pulse();

        // KMP fallback: 11101 -> 1,2,2,3 then match.
        s029 = 5'b11101;
        step(s029[4], 1'b1); chk("fb_s1", int'(st_ov), 1);
        step(s029[3], 1'b1); chk("fb_s2", int'(st_ov), 2);
        step(s029[2], 1'b1); chk("fb_s3", int'(st_ov), 2);
        step(s029[1], 1'b1); chk("fb_s4", int'(st_ov), 3); chk("fb_z4", int'(z_ov), 0);
        step(s029[0], 1'b1); chk("fb_z5", int'(z_ov), 1);
        reset_pulse();

        // Enable gaps with X toggling.
        step(1'b1, 1'b1);
        step(1'b0, 1'b0); step(1'b1, 1'b0); chk("gap_hold1", int'(st_ov), 1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("gap_hold2", int'(st_ov), 2);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0); step(1'b0, 1'b0); chk("gap_hold3", int'(st_ov), 3);
        chk("gap_noz", int'(z_ov), 0);
        step(1'b1, 1'b1); chk("gap_z", int'(z_ov), 1);
        step(1'b1, 1'b0); chk("gap_z_once", int'(z_ov), 0);
        reset_pulse();

        // Saturation: five back-to-back 1101 blocks give five matches.
        for (int r = 0; r < 5; r++) begin
            step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        end
        chk("sat_cnt_final", int'(c_sat), CNT_ON ? 3 : 0);
        chk("sat_flag_final", int'(s_sat), CNT_ON ? 1 : 0);
        chk("ov_cnt5", int'(c_ov), CNT_ON ? 5 : 0);
        reset_pulse();

        // Mixed stream exercising the 5-bit pattern and sporadic enables.
        long_x  = 32'hDB6D_B36D;
        long_en = 32'hFFBF_F7FE;
        for (int i = 31; i >= 0; i--) step(long_x[i], long_en[i]);
        step(1'b0, 1'b0);

        @(negedge CP);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
